// File: rtl/uart_time_parser.sv
// Parses "Thh:mm:ss" + CR/LF frames from a UART byte stream into BCD time
// fields with a valid/ready handshake toward the clock core.
module uart_time_parser #(
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       rx_data_ready,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       time_valid,
  input  logic       time_ready,
  output logic       cmd_err
);

  typedef enum logic [3:0] {
    IDLE, H1, H0, C1, M1, M0, C2, S1, S0, TERM
  } state_t;

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;

  state_t      state, state_nxt;
  logic [31:0] idle_cnt;
  logic [3:0]  hour_t, hour_u, min_t, min_u, sec_t, sec_u;
  logic        accept, byte_ok, is_digit, timeout, err_event, frame_done;
  logic [7:0]  digit_full;
  logic [3:0]  digit;

  assign is_digit   = (rx_data >= CH_0) && (rx_data <= 8'h39);
  assign digit_full = rx_data - CH_0;
  assign digit      = digit_full[3:0];
  assign timeout    = (TIMEOUT_CYC != 0) && (state != IDLE) &&
                      (idle_cnt == 32'(TIMEOUT_CYC));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: per-state byte check, resync on 'T', timeout when no byte arrives
  always_comb begin
    state_t succ;
    byte_ok   = 1'b0;
    succ      = IDLE;
    state_nxt = state;
    unique case (state)
      IDLE: begin byte_ok = (rx_data == CH_T);                                       succ = H1;   end
      H1:   begin byte_ok = is_digit && (rx_data <= 8'h32);                          succ = H0;   end
      H0:   begin byte_ok = is_digit && ((hour_t != 4'd2) || (rx_data <= 8'h33));    succ = C1;   end
      C1:   begin byte_ok = (rx_data == CH_COLON);                                   succ = M1;   end
      M1:   begin byte_ok = is_digit && (rx_data <= 8'h35);                          succ = M0;   end
      M0:   begin byte_ok = is_digit;                                                succ = C2;   end
      C2:   begin byte_ok = (rx_data == CH_COLON);                                   succ = S1;   end
      S1:   begin byte_ok = is_digit && (rx_data <= 8'h35);                          succ = S0;   end
      S0:   begin byte_ok = is_digit;                                                succ = TERM; end
      TERM: begin byte_ok = (rx_data == CH_CR) || (rx_data == CH_LF);                succ = IDLE; end
      default: begin byte_ok = 1'b0;                                                 succ = IDLE; end
    endcase
    if (accept) begin
      if (byte_ok)            state_nxt = succ;
      else if (state != IDLE) state_nxt = (rx_data == CH_T) ? H1 : IDLE;
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  // Handshake and event decode; an accepted byte masks a coincident timeout
  always_comb begin
    rx_data_ready = ~time_valid;
    accept        = rx_data_valid && rx_data_ready;
    frame_done    = accept && byte_ok && (state == TERM);
    err_event     = (accept && !byte_ok && (state != IDLE)) || (!accept && timeout);
  end

  // Idle counter, shadow digits, result and error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt   <= '0;
      hour_t     <= '0; hour_u <= '0;
      min_t      <= '0; min_u  <= '0;
      sec_t      <= '0; sec_u  <= '0;
      hour_bcd   <= '0;
      min_bcd    <= '0;
      sec_bcd    <= '0;
      time_valid <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      if (accept || state == IDLE || timeout) idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + 32'd1;

      if (err_event) begin
        hour_t <= '0; hour_u <= '0;
        min_t  <= '0; min_u  <= '0;
        sec_t  <= '0; sec_u  <= '0;
      end else if (accept && byte_ok) begin
        unique case (state)
          H1:      hour_t <= digit;
          H0:      hour_u <= digit;
          M1:      min_t  <= digit;
          M0:      min_u  <= digit;
          S1:      sec_t  <= digit;
          S0:      sec_u  <= digit;
          default: ;
        endcase
      end

      cmd_err <= err_event;

      if (frame_done) begin
        hour_bcd   <= {hour_t, hour_u};
        min_bcd    <= {min_t, min_u};
        sec_bcd    <= {sec_t, sec_u};
        time_valid <= 1'b1;
      end else if (time_ready) begin
        time_valid <= 1'b0;
      end
    end
  end

endmodule
